// File: rtl/div_ctrl_pkg.sv
// Shared constants for the iterative divider controller: FSM encodings,
// div_op bit positions and the iteration count.
package div_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PREP  = 3'd1;
  localparam state_t ST_CALC  = 3'd2;
  localparam state_t ST_FIXUP = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam int unsigned DIV_W  = 0;
  localparam int unsigned MOD_W  = 1;
  localparam int unsigned DIV_WU = 2;
  localparam int unsigned MOD_WU = 3;

  localparam int unsigned ITER_COUNT = 32;

  // Reduce a possibly zero or multi-hot op to one-hot by lowest set index;
  // all-zero falls back to div.w.
  function automatic logic [3:0] decode_op(input logic [3:0] op);
    logic [3:0] res;
    res = 4'b0001;
    if (op[DIV_W])       res = 4'b0001;
    else if (op[MOD_W])  res = 4'b0010;
    else if (op[DIV_WU]) res = 4'b0100;
    else if (op[MOD_WU]) res = 4'b1000;
    return res;
  endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// One combinational restoring shift-subtract step of the divider.
module div_step (
  input  logic [31:0] rem,
  input  logic        dvd_bit,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic        q_bit
);

  logic [32:0] wide;
  logic [32:0] diff;
  logic        borrow;
  logic        unused_msb;

  assign wide = {rem, dvd_bit};
  // 33-bit subtract with the borrow captured as an extra top bit.
  assign {borrow, diff} = {1'b0, wide} - {2'b00, divisor};
  // The restored or reduced value is always below the divisor, so bit 32 is zero.
  assign {unused_msb, rem_out} = borrow ? wide : diff;
  assign q_bit = ~borrow;

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit divide controller: accept, prepare magnitudes,
// 32 restoring iterations, sign fix-up, then hold the result until taken.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic [3:0]  div_op,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        div_flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] div_result,
  output logic        div_busy
);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] src1_q, src2_q;
  logic [3:0]  op_q;
  logic [31:0] dvd_q, dsr_q;
  logic [31:0] rem_q, quo_q;
  logic        qsign_q, rsign_q, dz_q;
  logic [31:0] res_q;

  logic        accept;
  logic        is_signed, is_mod;
  logic        cnt_last;
  logic [31:0] step_rem;
  logic        step_q;
  logic [31:0] q_fix, r_fix, fix_res;

  assign div_ready  = (state_q == ST_IDLE);
  assign accept     = div_valid & div_ready & ~div_flush;
  assign out_valid  = (state_q == ST_DONE);
  assign div_busy   = (state_q != ST_IDLE);
  assign div_result = out_valid ? res_q : 32'h0;

  assign is_signed = op_q[DIV_W] | op_q[MOD_W];
  assign is_mod    = op_q[MOD_W] | op_q[MOD_WU];
  assign cnt_last  = (cnt_q == 6'(ITER_COUNT - 1));

  div_step u_step (
    .rem     (rem_q),
    .dvd_bit (dvd_q[31]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Next-state selection; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_PREP;
      ST_PREP:  state_d = ST_CALC;
      ST_CALC:  if (cnt_last) state_d = ST_FIXUP;
      ST_FIXUP: state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (div_flush) state_d = ST_IDLE;
  end

  // Sign correction and divide-by-zero override for the final result.
  always_comb begin
    q_fix = qsign_q ? (32'h0 - quo_q) : quo_q;
    r_fix = rsign_q ? (32'h0 - rem_q) : rem_q;
    if (dz_q) fix_res = is_mod ? src1_q : 32'hFFFF_FFFF;
    else      fix_res = is_mod ? r_fix : q_fix;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers, advanced according to the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 6'd0;
      src1_q  <= 32'h0;
      src2_q  <= 32'h0;
      op_q    <= 4'h0;
      dvd_q   <= 32'h0;
      dsr_q   <= 32'h0;
      rem_q   <= 32'h0;
      quo_q   <= 32'h0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= 32'h0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            src1_q <= div_src1;
            src2_q <= div_src2;
            op_q   <= decode_op(div_op);
          end
        end
        ST_PREP: begin
          dvd_q   <= (is_signed && src1_q[31]) ? (32'h0 - src1_q) : src1_q;
          dsr_q   <= (is_signed && src2_q[31]) ? (32'h0 - src2_q) : src2_q;
          qsign_q <= is_signed & (src1_q[31] ^ src2_q[31]);
          rsign_q <= is_signed & src1_q[31];
          dz_q    <= (src2_q == 32'h0);
          rem_q   <= 32'h0;
          quo_q   <= 32'h0;
          cnt_q   <= 6'd0;
        end
        ST_CALC: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[30:0], step_q};
          dvd_q <= {dvd_q[30:0], 1'b0};
          cnt_q <= cnt_q + 6'd1;
        end
        ST_FIXUP: res_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule
